instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage of the mriscv core. Holds the program counter, issues word reads to instruction memory over a req/ack handshake and presents each fetched word to `instr_decode` on its `instr` input with a valid/ready handshake. Accepts redirects (taken branches, jal/jalr) from the execute stage and squashes wrong-path fetches. It drives the decode stage's instruction input and fills its own PC from redirect targets.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `NOP`, 32'h0000_0013 (addi x0,x0,0), value on `instr` whenever no valid word is held

- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `mem_req`  out  1  read request to instruction memory
- `mem_addr`  out  32  word address, bits [1:0] always 0
- `mem_ack`  in  1  read data valid this cycle; may be high in the same cycle `mem_req` rises
- `mem_rdata`  in  32  read data, sampled when `mem_req & mem_ack`
- `instr`  out  32  fetched instruction to `instr_decode`
- `instr_pc`  out  32  address of `instr`
- `instr_valid`  out  1  `instr` holds an unconsumed instruction
- `instr_ready`  in  1  decode accepts `instr` this cycle
- `redirect`  in  1  one-cycle pulse: next fetch at `redirect_pc`
- `redirect_pc`  in  32  redirect target
- `fault`  out  1  misaligned redirect target, sticky until reset

## Operation
- States: RESET_WAIT, REQ, HOLD, HALT.
- RESET_WAIT: entered asynchronously while `reset`=0. On the first clock after release, go to REQ with pc=`RESET_PC`.
- REQ:
  - `mem_req`=1 and `mem_addr`=pc, both held stable until ack.
  - On `mem_ack` with no kill pending: latch `instr`=`mem_rdata` and `instr_pc`=pc, set pc=pc+4, go to HOLD.
  - On `mem_ack` with kill pending: discard the data, clear kill, pc=saved redirect target, stay in REQ. `mem_req` stays high and the new address is presented the next cycle.
- HOLD:
  - `instr_valid`=1, `mem_req`=0.
  - On `instr_ready`: go to REQ (`instr_valid` drops).
  - Otherwise hold `instr`/`instr_pc` stable.
- Redirect with `redirect_pc[1:0]`=0:
  - In HOLD: drop the held instruction and go to REQ with pc=`redirect_pc`.
  - In REQ with no ack this cycle: set kill and save the target. A request in flight is never withdrawn.
  - In REQ with ack in the same cycle: discard the data and go to REQ at the target.
  - A second redirect while kill is pending overwrites the saved target.
- Redirect with `redirect_pc[1:0]`≠0: set `fault`=1, go to HALT. In HALT `mem_req`=0, `instr_valid`=0, and only reset exits.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Timing
- Reset values: `mem_req`=0, `mem_addr`=`RESET_PC`, `instr`=`NOP`, `instr_pc`=0, `instr_valid`=0, `fault`=0. Internal pc=`RESET_PC`, kill=0.
- All outputs are registered. `mem_addr` equals the registered pc.
- Latency: `mem_req` rises 1 cycle after reset release. An ack in the same cycle gives `instr_valid` the following cycle.
- Maximum throughput is 1 instruction per 2 cycles (REQ ↔ HOLD).
- Simultaneous `instr_ready` and `redirect` in HOLD: the transfer completes (decode squashes it on the same `redirect`) and fetch resumes at `redirect_pc`.
- Reset asserted mid-REQ: `mem_req` drops asynchronously. Memory tolerates the abandoned request.

## Structure
- Shared package `mriscv_pkg` holds:
  - the `NOP` constant
  - the default `RESET_PC`
  - the fetch state enum (`FETCH_RESET_WAIT`, `FETCH_REQ`, `FETCH_HOLD`, `FETCH_HALT`)
- Single module, no sub-modules. The PC register and kill/saved-target registers are inline.

## Test plan
- Reset, then memory acks every request in the same cycle with `mem_rdata`=`mem_addr`, `instr_ready`=1: `instr_pc`/`instr` step 0, 4, 8, … with `instr_valid` high every other cycle; `mem_req` first rises 1 cycle after release.
- `instr_ready`=0 for 5 cycles in HOLD: `instr`=32'h7D00_01EF (jal x3,2000) and `instr_pc` are held stable, and `mem_req` stays 0.
- Memory ack delayed 3 cycles, `redirect`=1 with `redirect_pc`=2000 in the first wait cycle: the stale word is not presented; the next `mem_addr` is 2000 and the next `instr_pc` is 2000.
- `redirect` in HOLD with `redirect_pc`=0x100 and `instr_ready`=1 in the same cycle: the next request is to 0x100.
- `redirect_pc`=0x102: `fault`=1, `mem_req` and `instr_valid` stay 0 thereafter, and only `reset`=0 clears `fault`.
- Redirect to 32'hFFFF_FFFC: fetch 0xFFFF_FFFC, then 0x0000_0000. Reset asserted mid-wait drops `mem_req` without a clock edge.

Source files
------------

// File: rtl/mriscv_pkg.sv
// Shared constants and types for the mriscv core pipeline stages.
package mriscv_pkg;

    localparam logic [31:0] NOP              = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_RESET_WAIT = 2'd0,
        FETCH_REQ        = 2'd1,
        FETCH_HOLD       = 2'd2,
        FETCH_HALT       = 2'd3
    } fetch_state_e;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, memory req/ack, valid/ready to decode, redirect
// handling with wrong-path squash of an in-flight request.
module instr_fetch
    import mriscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         kill_q, kill_d;
    logic [31:0]  kill_pc_q, kill_pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_pc_q, instr_pc_d;
    logic         mem_req_q, mem_req_d;
    logic         valid_q, valid_d;
    logic         fault_q, fault_d;

    logic redir_ok, redir_bad;

    assign redir_ok  = redirect &  is_word_aligned(redirect_pc);
    assign redir_bad = redirect & ~is_word_aligned(redirect_pc);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        kill_d     = kill_q;
        kill_pc_d  = kill_pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        mem_req_d  = mem_req_q;
        valid_d    = valid_q;
        fault_d    = fault_q;

        case (state_q)
            FETCH_RESET_WAIT: begin
                state_d   = FETCH_REQ;
                pc_d      = RESET_PC;
                mem_req_d = 1'b1;
            end

            FETCH_REQ: begin
                if (redir_bad) begin
                    state_d   = FETCH_HALT;
                    fault_d   = 1'b1;
                    kill_d    = 1'b0;
                    mem_req_d = 1'b0;
                end else if (redir_ok && mem_ack) begin
                    // Returning word is wrong-path; restart at the target directly.
                    pc_d   = redirect_pc;
                    kill_d = 1'b0;
                end else if (redir_ok) begin
                    // Request stays on the bus until acked; remember to drop its data.
                    kill_d    = 1'b1;
                    kill_pc_d = redirect_pc;
                end else if (mem_ack && kill_q) begin
                    pc_d   = kill_pc_q;
                    kill_d = 1'b0;
                end else if (mem_ack) begin
                    state_d    = FETCH_HOLD;
                    instr_d    = mem_rdata;
                    instr_pc_d = pc_q;
                    pc_d       = pc_q + 32'd4;
                    mem_req_d  = 1'b0;
                    valid_d    = 1'b1;
                end
            end

            FETCH_HOLD: begin
                if (redir_bad) begin
                    state_d = FETCH_HALT;
                    fault_d = 1'b1;
                    valid_d = 1'b0;
                    instr_d = NOP;
                end else if (redir_ok || instr_ready) begin
                    state_d   = FETCH_REQ;
                    valid_d   = 1'b0;
                    instr_d   = NOP;
                    mem_req_d = 1'b1;
                    if (redir_ok) pc_d = redirect_pc;
                end
            end

            FETCH_HALT: begin
                mem_req_d = 1'b0;
                valid_d   = 1'b0;
            end

            default: begin
                state_d = FETCH_RESET_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= FETCH_RESET_WAIT;
            pc_q       <= RESET_PC;
            kill_q     <= 1'b0;
            kill_pc_q  <= 32'd0;
            instr_q    <= NOP;
            instr_pc_q <= 32'd0;
            mem_req_q  <= 1'b0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            kill_q     <= kill_d;
            kill_pc_q  <= kill_pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            mem_req_q  <= mem_req_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a randomized run checked
// against a stream-level model of which (pc, word) pairs decode must accept.
module tb_instr_fetch;
    import mriscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        fault;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect(redirect), .redirect_pc(redirect_pc), .fault(fault)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Memory responder: lat >= 0 fixed wait cycles, lat < 0 random 0..3
    int          lat = 0;
    int          data_mode = 0;
    int          wcnt = -1;
    logic [31:0] fixed_word = 32'h7D00_01EF;

    function automatic logic [31:0] scr(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (data_mode == 0) return a;
        if (data_mode == 1) return fixed_word;
        return scr(a);
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        if (!mem_req) begin
            mem_ack = 1'b0;
            wcnt    = -1;
        end else begin
            if (wcnt < 0) wcnt = (lat >= 0) ? lat : int'($urandom_range(0, 3));
            if (wcnt == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_word(mem_addr);
                wcnt      = -1;
            end else begin
                mem_ack = 1'b0;
                wcnt--;
            end
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 30 && !instr_valid; i++) tick();
        chk(tag, instr_valid, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    logic [31:0] exp_pc;
    logic [31:0] prev_addr;
    logic        prev_wait;
    int          accepted;

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_instr", instr, NOP);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_fault", fault, 1'b0);

        // Streaming with same-cycle ack, rdata = addr
        instr_ready = 1'b1;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("stream_req", mem_req, 1'b1);
            chk("stream_addr", mem_addr, 32'(4 * k));
            chk("stream_valid_lo", instr_valid, 1'b0);
            tick();
            chk("stream_valid_hi", instr_valid, 1'b1);
            chk("stream_req_lo", mem_req, 1'b0);
            chk("stream_pc", instr_pc, 32'(4 * k));
            chk("stream_instr", instr, 32'(4 * k));
        end

        // Stall in HOLD
        data_mode = 1;
        tick();
        chk("hold_addr", mem_addr, 32'd16);
        instr_ready = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("hold_instr", instr, 32'h7D00_01EF);
            chk("hold_pc", instr_pc, 32'd16);
            chk("hold_req", mem_req, 1'b0);
            chk("hold_valid", instr_valid, 1'b1);
            tick();
        end

        // Slow memory, redirect during the first wait cycle
        lat = 3;
        data_mode = 0;
        instr_ready = 1'b1;
        tick();
        chk("kill_addr0", mem_addr, 32'd20);
        chk("kill_ack0", mem_ack, 1'b0);
        redirect = 1'b1;
        redirect_pc = 32'd2000;
        tick();
        redirect = 1'b0;
        chk("kill_inflight_req", mem_req, 1'b1);
        chk("kill_inflight_addr", mem_addr, 32'd20);
        for (int i = 0; i < 20 && mem_addr == 32'd20 && !instr_valid; i++) tick();
        chk("kill_no_stale", instr_valid, 1'b0);
        chk("kill_new_addr", mem_addr, 32'd2000);
        chk("kill_new_req", mem_req, 1'b1);
        wait_valid("kill_wait_valid");
        chk("kill_pc", instr_pc, 32'd2000);
        chk("kill_instr", instr, 32'd2000);

        // Redirect together with ready in HOLD
        lat = 0;
        redirect = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        chk("hredir_req", mem_req, 1'b1);
        chk("hredir_addr", mem_addr, 32'h100);
        chk("hredir_valid", instr_valid, 1'b0);
        tick();
        chk("hredir_pc", instr_pc, 32'h100);

        // PC wrap
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        chk("wrap_addr_top", mem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_pc_top", instr_pc, 32'hFFFF_FFFC);
        chk("wrap_instr_top", instr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr_zero", mem_addr, 32'h0);
        chk("wrap_req_zero", mem_req, 1'b1);
        tick();
        chk("wrap_pc_zero", instr_pc, 32'h0);

        // Reset while a request waits
        lat = 5;
        tick();
        chk("midrst_req_before", mem_req, 1'b1);
        #3 reset = 1'b0;
        #1;
        chk("midrst_req_async", mem_req, 1'b0);
        chk("midrst_addr", mem_addr, 32'h0);
        chk("midrst_instr", instr, NOP);
        tick();
        lat = 0;
        reset = 1'b1;

        // Misaligned redirect -> HALT
        wait_valid("fault_wait_valid");
        redirect = 1'b1;
        redirect_pc = 32'h102;
        tick();
        redirect_pc = 32'h200;
        chk("fault_set", fault, 1'b1);
        chk("fault_req", mem_req, 1'b0);
        chk("fault_valid", instr_valid, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            redirect = 1'b0;
            chk("halt_req", mem_req, 1'b0);
            chk("halt_valid", instr_valid, 1'b0);
            chk("halt_fault", fault, 1'b1);
        end
        #3 reset = 1'b0;
        #1;
        chk("fault_clear", fault, 1'b0);
        tick();

        // Randomized run against the accepted-stream model
        lat = -1;
        data_mode = 2;
        reset = 1'b1;
        exp_pc = 32'h0;
        prev_wait = 1'b0;
        prev_addr = 32'h0;
        accepted = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if (prev_wait && mem_req) chk("rnd_addr_stable", mem_addr, prev_addr);
            chk("rnd_addr_align", {30'd0, mem_addr[1:0]}, 32'd0);
            chk("rnd_req_xor_valid", {31'd0, mem_req & instr_valid}, 32'd0);
            if (!instr_valid) chk("rnd_nop", instr, NOP);
            chk("rnd_fault", fault, 1'b0);

            instr_ready = ($urandom_range(0, 1) == 1);
            redirect = (cyc > 2) && ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | ($urandom_range(0, 3) << 2);
            else redirect_pc = $urandom & 32'hFFFF_FFFC;

            if (instr_valid && instr_ready) begin
                chk("rnd_acc_pc", instr_pc, exp_pc);
                chk("rnd_acc_instr", instr, scr(exp_pc));
                exp_pc = exp_pc + 32'd4;
                accepted++;
            end
            if (redirect) exp_pc = redirect_pc;

            prev_wait = mem_req && !mem_ack;
            prev_addr = mem_addr;
        end
        redirect = 1'b0;
        chk("rnd_progress", {31'd0, accepted > 100}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
